// File: rtl/problem_d_pkg.sv
// Shared mode encodings for the parity counter.
package problem_d_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_EVEN = 2'b00;
   localparam mode_t MODE_ODD  = 2'b01;
   localparam mode_t MODE_LOAD = 2'b10;
   localparam mode_t MODE_HOLD = 2'b11;

endpackage

// File: rtl/problem_d_next.sv
// Combinational next-state function of the parity counter: (A, Z) -> next Z.
module problem_d_next
   import problem_d_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [1:0]       a,
   input  logic [WIDTH-1:0] z,
   output logic [WIDTH-1:0] z_next
);

   localparam logic [WIDTH-1:0] STEP = WIDTH'(2);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   always_comb begin
      z_next = z;
      case (mode_t'(a))
         // A value of the wrong parity realigns first; stepping resumes next cycle.
         MODE_EVEN: z_next = z[0] ? '0 : z + STEP;
         MODE_ODD:  z_next = z[0] ? z + STEP : ONE;
         MODE_LOAD: z_next = '1;
         default:   z_next = z;
      endcase
   end

endmodule

// File: rtl/problem_d.sv
// Mode-controlled parity counter: state register with synchronous active-low reset.
module problem_d
   import problem_d_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       A,
   output logic [WIDTH-1:0] Z
);

   logic [WIDTH-1:0] z_reg;
   logic [WIDTH-1:0] z_next;

   problem_d_next #(
      .WIDTH(WIDTH)
   ) u_next (
      .a      (A),
      .z      (z_reg),
      .z_next (z_next)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         z_reg <= '0;
      end else begin
         z_reg <= z_next;
      end
   end

   assign Z = z_reg;

endmodule

// File: tb/tb_problem_d.sv
// Directed, table-driven bench for the parity counter (WIDTH=4).
module tb_problem_d;

   localparam int WIDTH = 4;

   typedef struct {
      logic             rst_n;
      logic [1:0]       a;
      logic [WIDTH-1:0] exp_z;
      string            name;
   } vec_t;

   logic             clk;
   logic             reset;
   logic [1:0]       A;
   logic [WIDTH-1:0] Z;

   int n_cmp;
   int n_bad;
   vec_t vecs[$];

   problem_d #(
      .WIDTH(WIDTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .A     (A),
      .Z     (Z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic r, input logic [1:0] a, input logic [WIDTH-1:0] e,
                      input string nm);
      vec_t v;
      v.rst_n = r;
      v.a     = a;
      v.exp_z = e;
      v.name  = nm;
      vecs.push_back(v);
   endtask

   task automatic check(input string nm, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: Z=%0d expected %0d at %0t", nm, act, exp, $time);
      end else begin
         $display("ok   %s: Z=%0d at %0t", nm, act, $time);
      end
   endtask

   // Inputs change on the falling edge; Z is sampled 1 ns after the rising edge.
   task automatic step(input logic r, input logic [1:0] a);
      @(negedge clk);
      reset = r;
      A     = a;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b0;
      A     = 2'b11;

      add(1'b0, 2'b11, 4'd0, "reset0");
      add(1'b0, 2'b11, 4'd0, "reset1");
      for (int i = 1; i <= 8; i++)
         add(1'b1, 2'b00, 4'((2 * i) % 16), $sformatf("even%0d", i));
      for (int i = 0; i < 3; i++)
         add(1'b1, 2'b11, 4'd0, $sformatf("hold%0d", i));
      add(1'b1, 2'b10, 4'd15, "load");
      for (int i = 0; i < 8; i++)
         add(1'b1, 2'b01, 4'(2 * i + 1), $sformatf("odd%0d", i));
      add(1'b1, 2'b00, 4'd0, "realign_even");
      add(1'b1, 2'b00, 4'd2, "even_after_realign");
      add(1'b1, 2'b01, 4'd1, "realign_odd");
      add(1'b1, 2'b01, 4'd3, "odd_after_realign");

      foreach (vecs[i]) begin
         step(vecs[i].rst_n, vecs[i].a);
         check(vecs[i].name, Z, vecs[i].exp_z);
      end

      // Reset asserted between edges must not touch Z until the next edge.
      A = 2'b11;
      #2;
      reset = 1'b0;
      #3;
      check("midcycle_reset_no_effect", Z, 4'd3);
      @(posedge clk);
      #1;
      check("midcycle_reset_at_edge", Z, 4'd0);

      step(1'b1, 2'b01);
      check("odd_from_zero", Z, 4'd1);
      step(1'b0, 2'b10);
      check("reset_priority_over_load", Z, 4'd0);
      step(1'b1, 2'b10);
      check("load_after_release", Z, 4'd15);
      step(1'b1, 2'b10);
      check("load_repeat", Z, 4'd15);
      step(1'b1, 2'b01);
      check("odd_wrap_15_to_1", Z, 4'd1);
      step(1'b1, 2'b01);
      check("odd_after_wrap", Z, 4'd3);
      step(1'b1, 2'b11);
      check("hold_nonzero", Z, 4'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
